// File: rtl/idu_rf_pipe_hold.sv
// Register-read stage for one issue pipe: one-slot valid/ready buffer with forwarding
// and operand freeze on stall. Optional hardwired-zero preg 0 under IDU_RF_ZERO_PREG_EN.
module idu_rf_pipe_hold #(
    parameter int SRC_NUM = 2,
    parameter int FWD_NUM = 8,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64,
    parameter int IID_W   = 5,
    parameter int OP_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst_clk,
    input  logic                      rtu_global_flush,
    input  logic                      idu_rf_vld,
    output logic                      idu_rf_rdy,
    input  logic [IID_W-1:0]          idu_rf_iid,
    input  logic [OP_W-1:0]           idu_rf_opcode,
    input  logic [SRC_NUM-1:0]        idu_rf_psrc_vld,
    input  logic [SRC_NUM*PREG_W-1:0] idu_rf_psrc,
    input  logic                      idu_rf_imm_vld,
    input  logic [DATA_W-1:0]         idu_rf_imm,
    input  logic [FWD_NUM-1:0]        fwd_vld,
    input  logic [FWD_NUM*PREG_W-1:0] fwd_preg,
    input  logic [FWD_NUM*DATA_W-1:0] fwd_result,
    output logic [SRC_NUM-1:0]        x_rf_preg_psrc_vld,
    output logic [SRC_NUM*PREG_W-1:0] x_rf_preg_psrc,
    input  logic [SRC_NUM*DATA_W-1:0] x_rf_psrc_value,
    output logic                      pipe_vld,
    input  logic                      pipe_rdy,
    output logic [IID_W-1:0]          pipe_iid,
    output logic [OP_W-1:0]           pipe_opcode,
    output logic [SRC_NUM-1:0]        pipe_src_vld,
    output logic [SRC_NUM*DATA_W-1:0] pipe_src_value,
    output logic                      pipe_imm_vld,
    output logic [DATA_W-1:0]         pipe_imm
);

    logic                      slot_vld_q, slot_vld_d;
    logic [IID_W-1:0]          iid_q, iid_d;
    logic [OP_W-1:0]           opcode_q, opcode_d;
    logic [SRC_NUM-1:0]        psrc_vld_q, psrc_vld_d;
    logic [SRC_NUM*PREG_W-1:0] psrc_q, psrc_d;
    logic                      imm_vld_q, imm_vld_d;
    logic [DATA_W-1:0]         imm_q, imm_d;
    logic [SRC_NUM-1:0]        cap_q, cap_d;
    logic [SRC_NUM*DATA_W-1:0] hold_q, hold_d;

    wire  [SRC_NUM*DATA_W-1:0] res_val;
    wire  [SRC_NUM-1:0]        src_zero;
    logic                      load;
    logic                      fire;

    assign idu_rf_rdy = ~slot_vld_q | pipe_rdy;
    assign load       = idu_rf_vld & idu_rf_rdy;
    assign fire       = slot_vld_q & pipe_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
            logic [PREG_W-1:0] preg;
            logic [DATA_W-1:0] res;

            assign preg = psrc_q[gi*PREG_W +: PREG_W];
`ifdef IDU_RF_ZERO_PREG_EN
            assign src_zero[gi] = (preg == '0);
`else
            assign src_zero[gi] = 1'b0;
`endif
            // Scan from the highest index down so the lowest matching bus wins.
            always_comb begin
                res = x_rf_psrc_value[gi*DATA_W +: DATA_W];
                for (int j = FWD_NUM - 1; j >= 0; j--) begin
                    if (fwd_vld[j] && (fwd_preg[j*PREG_W +: PREG_W] == preg)) begin
                        res = fwd_result[j*DATA_W +: DATA_W];
                    end
                end
                if (src_zero[gi]) begin
                    res = '0;
                end
            end

            assign res_val[gi*DATA_W +: DATA_W] = res;
            assign pipe_src_value[gi*DATA_W +: DATA_W] =
                (slot_vld_q & psrc_vld_q[gi]) ? (cap_q[gi] ? hold_q[gi*DATA_W +: DATA_W] : res) : '0;
            assign x_rf_preg_psrc_vld[gi] = slot_vld_q & psrc_vld_q[gi] & ~cap_q[gi] & ~src_zero[gi];
            assign x_rf_preg_psrc[gi*PREG_W +: PREG_W] = slot_vld_q ? preg : '0;
        end
    endgenerate

    always_comb begin
        slot_vld_d = slot_vld_q;
        iid_d      = iid_q;
        opcode_d   = opcode_q;
        psrc_vld_d = psrc_vld_q;
        psrc_d     = psrc_q;
        imm_vld_d  = imm_vld_q;
        imm_d      = imm_q;
        cap_d      = cap_q;
        hold_d     = hold_q;
        if (rtu_global_flush || (!load && fire)) begin
            slot_vld_d = 1'b0;
            iid_d      = '0;
            opcode_d   = '0;
            psrc_vld_d = '0;
            psrc_d     = '0;
            imm_vld_d  = 1'b0;
            imm_d      = '0;
            cap_d      = '0;
            hold_d     = '0;
        end else if (load) begin
            slot_vld_d = 1'b1;
            iid_d      = idu_rf_iid;
            opcode_d   = idu_rf_opcode;
            psrc_vld_d = idu_rf_psrc_vld;
            psrc_d     = idu_rf_psrc;
            imm_vld_d  = idu_rf_imm_vld;
            imm_d      = idu_rf_imm;
            cap_d      = '0;
            hold_d     = '0;
        end else if (slot_vld_q) begin
            // Stall: freeze each live operand so later bus traffic cannot disturb it.
            for (int i = 0; i < SRC_NUM; i++) begin
                if (psrc_vld_q[i] && !cap_q[i]) begin
                    hold_d[i*DATA_W +: DATA_W] = res_val[i*DATA_W +: DATA_W];
                    cap_d[i]                   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            slot_vld_q <= 1'b0;
            iid_q      <= '0;
            opcode_q   <= '0;
            psrc_vld_q <= '0;
            psrc_q     <= '0;
            imm_vld_q  <= 1'b0;
            imm_q      <= '0;
            cap_q      <= '0;
            hold_q     <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            iid_q      <= iid_d;
            opcode_q   <= opcode_d;
            psrc_vld_q <= psrc_vld_d;
            psrc_q     <= psrc_d;
            imm_vld_q  <= imm_vld_d;
            imm_q      <= imm_d;
            cap_q      <= cap_d;
            hold_q     <= hold_d;
        end
    end

    assign pipe_vld     = slot_vld_q;
    assign pipe_iid     = iid_q;
    assign pipe_opcode  = opcode_q;
    assign pipe_src_vld = psrc_vld_q;
    assign pipe_imm_vld = imm_vld_q;
    assign pipe_imm     = imm_q;

endmodule

// File: tb/tb_idu_rf_pipe_hold.sv
// Bench for idu_rf_pipe_hold: directed scenarios plus random traffic checked
// against a transaction-level slot model with an array-backed register file.
module tb_idu_rf_pipe_hold;
    localparam int SRC_NUM = 2;
    localparam int FWD_NUM = 8;
    localparam int PREG_W  = 6;
    localparam int DATA_W  = 64;
    localparam int IID_W   = 5;
    localparam int OP_W    = 7;

    logic                      clk = 1'b0;
    logic                      rst_clk;
    logic                      rtu_global_flush;
    logic                      idu_rf_vld;
    logic                      idu_rf_rdy;
    logic [IID_W-1:0]          idu_rf_iid;
    logic [OP_W-1:0]           idu_rf_opcode;
    logic [SRC_NUM-1:0]        idu_rf_psrc_vld;
    logic [SRC_NUM*PREG_W-1:0] idu_rf_psrc;
    logic                      idu_rf_imm_vld;
    logic [DATA_W-1:0]         idu_rf_imm;
    logic [FWD_NUM-1:0]        fwd_vld;
    logic [FWD_NUM*PREG_W-1:0] fwd_preg;
    logic [FWD_NUM*DATA_W-1:0] fwd_result;
    logic [SRC_NUM-1:0]        x_rf_preg_psrc_vld;
    logic [SRC_NUM*PREG_W-1:0] x_rf_preg_psrc;
    logic [SRC_NUM*DATA_W-1:0] x_rf_psrc_value;
    logic                      pipe_vld;
    logic                      pipe_rdy;
    logic [IID_W-1:0]          pipe_iid;
    logic [OP_W-1:0]           pipe_opcode;
    logic [SRC_NUM-1:0]        pipe_src_vld;
    logic [SRC_NUM*DATA_W-1:0] pipe_src_value;
    logic                      pipe_imm_vld;
    logic [DATA_W-1:0]         pipe_imm;

    idu_rf_pipe_hold #(
        .SRC_NUM(SRC_NUM), .FWD_NUM(FWD_NUM), .PREG_W(PREG_W),
        .DATA_W(DATA_W), .IID_W(IID_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
        .idu_rf_vld(idu_rf_vld), .idu_rf_rdy(idu_rf_rdy), .idu_rf_iid(idu_rf_iid),
        .idu_rf_opcode(idu_rf_opcode), .idu_rf_psrc_vld(idu_rf_psrc_vld),
        .idu_rf_psrc(idu_rf_psrc), .idu_rf_imm_vld(idu_rf_imm_vld), .idu_rf_imm(idu_rf_imm),
        .fwd_vld(fwd_vld), .fwd_preg(fwd_preg), .fwd_result(fwd_result),
        .x_rf_preg_psrc_vld(x_rf_preg_psrc_vld), .x_rf_preg_psrc(x_rf_preg_psrc),
        .x_rf_psrc_value(x_rf_psrc_value), .pipe_vld(pipe_vld), .pipe_rdy(pipe_rdy),
        .pipe_iid(pipe_iid), .pipe_opcode(pipe_opcode), .pipe_src_vld(pipe_src_vld),
        .pipe_src_value(pipe_src_value), .pipe_imm_vld(pipe_imm_vld), .pipe_imm(pipe_imm)
    );

    always #5 clk = ~clk;

    // Register file model answering the DUT's read addresses combinationally.
    logic [DATA_W-1:0] rf_mem [0:(1<<PREG_W)-1];
    always_comb begin
        x_rf_psrc_value = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            x_rf_psrc_value[i*DATA_W +: DATA_W] = rf_mem[x_rf_preg_psrc[i*PREG_W +: PREG_W]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Slot model: one held operation with per-source frozen values.
    typedef struct {
        bit                vld;
        logic [IID_W-1:0]  iid;
        logic [OP_W-1:0]   op;
        bit                svld [SRC_NUM];
        logic [PREG_W-1:0] preg [SRC_NUM];
        bit                ivld;
        logic [DATA_W-1:0] imm;
        bit                frozen [SRC_NUM];
        logic [DATA_W-1:0] frozen_val [SRC_NUM];
    } slot_t;

    slot_t m;

    function automatic slot_t empty_slot();
        slot_t s;
        s.vld = 0; s.iid = '0; s.op = '0; s.ivld = 0; s.imm = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            s.svld[i] = 0; s.preg[i] = '0; s.frozen[i] = 0; s.frozen_val[i] = '0;
        end
        return s;
    endfunction

    function automatic bit is_zero_preg(input logic [PREG_W-1:0] p);
`ifdef IDU_RF_ZERO_PREG_EN
        return p == '0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] value_of(input logic [PREG_W-1:0] p);
        if (is_zero_preg(p)) return '0;
        for (int j = 0; j < FWD_NUM; j++) begin
            if (fwd_vld[j] && fwd_preg[j*PREG_W +: PREG_W] == p) return fwd_result[j*DATA_W +: DATA_W];
        end
        return rf_mem[p];
    endfunction

    task automatic check_model();
        logic [DATA_W-1:0] ev;
        check("pipe_vld", pipe_vld, m.vld);
        check("idu_rf_rdy", idu_rf_rdy, !m.vld || pipe_rdy);
        check("pipe_iid", pipe_iid, m.iid);
        check("pipe_opcode", pipe_opcode, m.op);
        check("pipe_imm_vld", pipe_imm_vld, m.ivld);
        check("pipe_imm", pipe_imm, m.imm);
        for (int i = 0; i < SRC_NUM; i++) begin
            if (!m.vld || !m.svld[i]) ev = '0;
            else if (m.frozen[i]) ev = m.frozen_val[i];
            else ev = value_of(m.preg[i]);
            check($sformatf("src_vld%0d", i), pipe_src_vld[i], m.svld[i]);
            check($sformatf("src_val%0d", i), pipe_src_value[i*DATA_W +: DATA_W], ev);
            check($sformatf("rf_ren%0d", i), x_rf_preg_psrc_vld[i],
                  m.vld && m.svld[i] && !m.frozen[i] && !is_zero_preg(m.preg[i]));
            check($sformatf("rf_addr%0d", i), x_rf_preg_psrc[i*PREG_W +: PREG_W], m.vld ? m.preg[i] : '0);
        end
    endtask

    task automatic model_edge();
        bit accept;
        accept = idu_rf_vld && (!m.vld || pipe_rdy);
        if (rtu_global_flush) begin
            m = empty_slot();
        end else if (accept) begin
            m = empty_slot();
            m.vld = 1; m.iid = idu_rf_iid; m.op = idu_rf_opcode;
            m.ivld = idu_rf_imm_vld; m.imm = idu_rf_imm;
            for (int i = 0; i < SRC_NUM; i++) begin
                m.svld[i] = idu_rf_psrc_vld[i];
                m.preg[i] = idu_rf_psrc[i*PREG_W +: PREG_W];
            end
        end else if (m.vld && pipe_rdy) begin
            m = empty_slot();
        end else if (m.vld) begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (m.svld[i] && !m.frozen[i]) begin
                    m.frozen_val[i] = value_of(m.preg[i]);
                    m.frozen[i] = 1;
                end
            end
        end
    endtask

    task automatic settle();
        #3;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rtu_global_flush = 0; idu_rf_vld = 0; idu_rf_iid = '0; idu_rf_opcode = '0;
        idu_rf_psrc_vld = '0; idu_rf_psrc = '0; idu_rf_imm_vld = 0; idu_rf_imm = '0;
        fwd_vld = '0; fwd_preg = '0; fwd_result = '0; pipe_rdy = 1;
    endtask

    task automatic issue(input logic [IID_W-1:0] iid, input logic [PREG_W-1:0] p0);
        idu_rf_vld = 1; idu_rf_iid = iid; idu_rf_opcode = 7'h21;
        idu_rf_psrc_vld = 2'b01; idu_rf_psrc = '0; idu_rf_psrc[PREG_W-1:0] = p0;
    endtask

    initial begin
        for (int k = 0; k < (1 << PREG_W); k++) rf_mem[k] = 64'h1000 + 64'(k);
        idle();
        pipe_rdy = 0;
        rst_clk = 0;
        m = empty_slot();
        #2;
        check_model();
        @(posedge clk);
        #1 rst_clk = 1;

        // Plain RF read, 1-cycle latency.
        rf_mem[5] = 64'h11;
        idle(); issue(5'd3, 6'd5);
        settle(); tick();
        idle();
        settle();
        check("t1_vld", pipe_vld, 1);
        check("t1_iid", pipe_iid, 3);
        check("t1_src0", pipe_src_value[63:0], 64'h11);
        check("t1_ren", x_rf_preg_psrc_vld[0], 1);
        tick();

        // Forwarding priority: bus 2 beats bus 6.
        issue(5'd4, 6'd9);
        settle(); tick();
        idle();
        fwd_vld[2] = 1; fwd_preg[2*PREG_W +: PREG_W] = 6'd9; fwd_result[2*DATA_W +: DATA_W] = 64'hAA;
        fwd_vld[6] = 1; fwd_preg[6*PREG_W +: PREG_W] = 6'd9; fwd_result[6*DATA_W +: DATA_W] = 64'hBB;
        settle();
        check("t2_prio", pipe_src_value[63:0], 64'hAA);
        tick();

        // Stall freezes the forwarded value.
        idle(); issue(5'd5, 6'd4);
        settle(); tick();
        idle(); pipe_rdy = 0;
        fwd_vld[0] = 1; fwd_preg[PREG_W-1:0] = 6'd4; fwd_result[DATA_W-1:0] = 64'h55;
        settle();
        check("t3_first", pipe_src_value[63:0], 64'h55);
        tick();
        fwd_result[DATA_W-1:0] = 64'h99; rf_mem[4] = 64'h77;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("t3_hold", pipe_src_value[63:0], 64'h55);
            check("t3_ren", x_rf_preg_psrc_vld[0], 0);
            check("t3_rdy", idu_rf_rdy, 0);
            tick();
        end
        pipe_rdy = 1;
        settle(); tick();
        idle(); settle();
        check("t3_fired", pipe_vld, 0);
        tick();

        // Back-to-back issue, no bubbles.
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) issue(5'(10 + k), 6'(20 + k));
            settle();
            if (k > 0) begin
                check("t4_vld", pipe_vld, 1);
                check("t4_iid", pipe_iid, 5'(10 + k - 1));
            end
            tick();
        end

        // Flush during stall with a same-cycle issue.
        idle(); issue(5'd7, 6'd2);
        settle(); tick();
        idle(); pipe_rdy = 0;
        settle(); tick();
        issue(5'd8, 6'd3); rtu_global_flush = 1;
        settle(); tick();
        idle(); pipe_rdy = 0;
        settle();
        check("t5_vld", pipe_vld, 0);
        check("t5_iid", pipe_iid, 0);
        check("t5_src", pipe_src_value[63:0], 0);
        tick();

        // Preg 0 with a matching forwarding bus.
        idle(); issue(5'd9, 6'd0);
        settle(); tick();
        idle();
        rf_mem[0] = 64'h33;
        fwd_vld[1] = 1; fwd_preg[PREG_W +: PREG_W] = 6'd0; fwd_result[DATA_W +: DATA_W] = 64'hFF;
        settle();
`ifdef IDU_RF_ZERO_PREG_EN
        check("t6_src0", pipe_src_value[63:0], 64'h0);
        check("t6_ren", x_rf_preg_psrc_vld[0], 0);
`else
        check("t6_src0", pipe_src_value[63:0], 64'hFF);
        check("t6_ren", x_rf_preg_psrc_vld[0], 1);
`endif
        tick();

        // Asynchronous reset in the middle of a stall.
        idle(); issue(5'd11, 6'd6);
        settle(); tick();
        idle(); pipe_rdy = 0;
        settle();
        #2 rst_clk = 0;
        #1;
        check("rst_vld", pipe_vld, 0);
        check("rst_rdy", idu_rf_rdy, 1);
        check("rst_iid", pipe_iid, 0);
        check("rst_ren", x_rf_preg_psrc_vld, 0);
        m = empty_slot();
        @(posedge clk);
        #1 rst_clk = 1;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            idu_rf_vld = ($urandom_range(0, 9) < 7);
            idu_rf_iid = IID_W'($urandom);
            idu_rf_opcode = OP_W'($urandom);
            idu_rf_psrc_vld = SRC_NUM'($urandom);
            for (int i = 0; i < SRC_NUM; i++) idu_rf_psrc[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
            idu_rf_imm_vld = 1'($urandom);
            idu_rf_imm = {$urandom, $urandom};
            for (int j = 0; j < FWD_NUM; j++) begin
                fwd_vld[j] = ($urandom_range(0, 3) == 0);
                fwd_preg[j*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 7));
                fwd_result[j*DATA_W +: DATA_W] = {$urandom, $urandom};
            end
            pipe_rdy = ($urandom_range(0, 9) < 6);
            rtu_global_flush = ($urandom_range(0, 24) == 0);
            rf_mem[$urandom_range(0, 7)] = {$urandom, $urandom};
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idu_rf_pipe_hold.md
Name: idu_rf_pipe_hold

Overview:
- Parametrised register-read stage for one issue pipe, successor to the single-source RF pipe stage.
- Supports SRC_NUM source operands and FWD_NUM forwarding buses, with deterministic priority between forwarding buses.
- Adds a valid/ready handshake: when the execution unit stalls, the operation is held and its resolved operand values are frozen.
- Sits between IDU issue and the EXU pipe; drives read ports on the physical register file.

Parameters:
SRC_NUM, 2, number of source operands (1..3)
FWD_NUM, 8, number of forwarding buses (EX and CDB, any order; index 0 has highest priority)
PREG_W, 6, physical register index width
DATA_W, 64, operand and immediate width
IID_W, 5, instruction id width
OP_W, 7, opcode width

Ports:
clk  in  1  clock
rst_clk  in  1  asynchronous active-low reset
rtu_global_flush  in  1  synchronous pipeline flush
idu_rf_vld  in  1  issue valid
idu_rf_rdy  out  1  stage can accept an operation
idu_rf_iid  in  IID_W  instruction id
idu_rf_opcode  in  OP_W  opcode
idu_rf_psrc_vld  in  SRC_NUM  per-source valid
idu_rf_psrc  in  SRC_NUM*PREG_W  per-source preg; source i occupies bits [i*PREG_W +: PREG_W]
idu_rf_imm_vld  in  1  immediate valid
idu_rf_imm  in  DATA_W  immediate
fwd_vld  in  FWD_NUM  forwarding bus valid
fwd_preg  in  FWD_NUM*PREG_W  forwarding bus destination preg
fwd_result  in  FWD_NUM*DATA_W  forwarding bus result
x_rf_preg_psrc_vld  out  SRC_NUM  RF read enable
x_rf_preg_psrc  out  SRC_NUM*PREG_W  RF read address
x_rf_psrc_value  in  SRC_NUM*DATA_W  RF read data, combinational in the same cycle
pipe_vld  out  1  operation valid to EXU
pipe_rdy  in  1  EXU accepts
pipe_iid  out  IID_W  instruction id
pipe_opcode  out  OP_W  opcode
pipe_src_vld  out  SRC_NUM  source valid
pipe_src_value  out  SRC_NUM*DATA_W  resolved operands
pipe_imm_vld  out  1  immediate valid
pipe_imm  out  DATA_W  immediate

Behaviour:
- Reset: all registered state and every output is 0. Exception: idu_rf_rdy = 1.
- The stage holds one slot, slot_vld. pipe_vld = slot_vld.
- Handshakes:
  - idu_rf_rdy = !slot_vld | pipe_rdy.
  - Load occurs when idu_rf_vld & idu_rf_rdy.
  - Fire occurs when pipe_vld & pipe_rdy.
- Per-cycle slot update, in priority order:
  1. rtu_global_flush: slot_vld=0, all payload and capture flags cleared. Issue in the same cycle is dropped.
  2. Load: slot takes the new payload, capture flags are cleared, slot_vld=1. Load and fire in the same cycle gives back-to-back throughput of 1 op/cycle.
  3. Fire without load: slot_vld=0, payload cleared to 0.
  4. Otherwise (stall): the slot is held. For each valid, uncaptured source, the current resolved value is written into hold[i] and cap[i] is set.
- Per-source state is {LIVE, CAPTURED}:
  - LIVE on load; LIVE to CAPTURED on the first stall cycle.
  - CAPTURED persists until fire or flush.
- Operand resolution for source i while LIVE:
  - The lowest-index j with fwd_vld[j] & fwd_preg[j]==psrc[i] supplies fwd_result[j].
  - If there is no match, x_rf_psrc_value[i] supplies the value.
- Operand output:
  - pipe_src_value[i] = cap[i] ? hold[i] : resolved value.
  - Forwarding buses are ignored once a source is captured.
  - pipe_src_value[i] = 0 when pipe_src_vld[i]=0 or slot empty.
- x_rf_preg_psrc_vld[i] = slot_vld & psrc_vld[i] & !cap[i]. No RF read is issued while a source is held.
- x_rf_preg_psrc carries the registered slot pregs, or 0 when the slot is empty.
- Latency: 1 cycle from issue to pipe_vld. Operand values are combinational in the pipe_vld cycle.
- Multiple matching forwarding buses with differing data: the lowest index wins and no error is flagged.
- rtu_global_flush during a stall discards the held op; pipe_vld=0 in the next cycle.
- Reset mid-stall: everything returns to reset values immediately (asynchronous reset).

Optional Feature:
- Macro: IDU_RF_ZERO_PREG_EN.
- Defined:
  - preg 0 is hardwired zero: a valid source with psrc==0 resolves to 0.
  - That source never matches a forwarding bus.
  - Its x_rf_preg_psrc_vld bit is held 0.
- Undefined: preg 0 is treated like any other register.

Test Plan:
- Issue iid=3, psrc0=5, RF[5]=0x11, no forwarding, pipe_rdy=1 -> next cycle pipe_vld=1, iid=3, src0=0x11, x_rf_preg_psrc_vld[0]=1.
- psrc0=9, fwd_vld[2] and fwd_vld[6] both set with preg 9, results 0xAA and 0xBB -> src0=0xAA (index 2 wins over index 6).
- Hold: load psrc0=4 with fwd[0]={4,0x55}, then pipe_rdy=0 for 3 cycles while fwd[0] changes to {4,0x99} and RF[4]=0x77 -> src0 stays 0x55, x_rf_preg_psrc_vld[0]=0 and idu_rf_rdy=0 during the stall; fire on pipe_rdy=1.
- Back-to-back: issue on 4 consecutive cycles with pipe_rdy=1 -> 4 consecutive pipe_vld cycles with iids in order and no bubbles.
- Flush during a stall, with an issue in the same cycle -> next cycle pipe_vld=0 and all outputs 0; the issued op is not presented.
- IDU_RF_ZERO_PREG_EN defined, psrc0=0 valid, fwd[1]={0,0xFF} -> src0=0, RF read enable 0. Undefined -> src0=0xFF.
